// File: rtl/act_s2_arbiter_if.sv
// act_s2_arbiter_if
//   Handshake bundle between the requesters, the response consumer and
//   act_s2_arbiter.
//
//   req_valid [REQS]        requester i presents an operand set
//   req_ready [REQS]        operand set i accepted this cycle (one-hot or zero)
//   req_sel   [4*REQS]      slice i = {A1,B1,A0,B0}
//   req_d     [4*BITS*REQS] slice i = {D11,D10,D01,D00}
//   rsp_valid               response available
//   rsp_ready               consumer accepts response
//   rsp_id    [IDW]         requester index of the response
//   rsp_data  [BITS]        cell result
//
//   master: requester/consumer side.  slave: arbiter side.
interface act_s2_arbiter_if #(
    parameter int BITS = 2,
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
);
    logic [REQS-1:0]        req_valid;
    logic [REQS-1:0]        req_ready;
    logic [4*REQS-1:0]      req_sel;
    logic [4*BITS*REQS-1:0] req_d;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [BITS-1:0]        rsp_data;

    modport master (
        output req_valid, req_sel, req_d, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_sel, req_d, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/act_s2_arbiter.sv
// act_s2_arbiter
//   Round-robin arbiter that time-shares one registered ACT-S2 logic cell
//   among REQS requesters. One operand set is accepted at a time, held in
//   registers that drive the cell, and the cell's registered result is
//   returned with the id of the requester that supplied it.
//
//   clock                  single clock, all state on posedge
//   reset                  synchronous, active-low
//   bus (slave)            request / response handshake (act_s2_arbiter_if)
//   cell_A1/B1/A0/B0       cell select inputs (from hold register)
//   cell_D00..cell_D11     cell data inputs (from hold register)
//   cell_reset             cell reset, active-high, equals ~reset
//   cell_out               registered cell output
//   busy                   high whenever the FSM is not IDLE
module act_s2_arbiter #(
    parameter int BITS = 2,
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
) (
    input  logic            clock,
    input  logic            reset,
    act_s2_arbiter_if.slave bus,
    output logic            cell_A1,
    output logic            cell_B1,
    output logic            cell_A0,
    output logic            cell_B0,
    output logic [BITS-1:0] cell_D00,
    output logic [BITS-1:0] cell_D01,
    output logic [BITS-1:0] cell_D10,
    output logic [BITS-1:0] cell_D11,
    output logic            cell_reset,
    input  logic [BITS-1:0] cell_out,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [IDW-1:0]    rr;
    logic [3:0]        hold_sel;
    logic [4*BITS-1:0] hold_d;
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [BITS-1:0]   rsp_data_q;

    logic              grant_vld;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic              accept;
    logic [REQS-1:0]   req_ready_c;

    // Per-requester views of the flat operand buses.
    logic [3:0]        sel_arr [REQS];
    logic [4*BITS-1:0] d_arr   [REQS];

    for (genvar g = 0; g < REQS; g++) begin : g_unpack
        assign sel_arr[g] = bus.req_sel[4*g +: 4];
        assign d_arr[g]   = bus.req_d[4*BITS*g +: 4*BITS];
    end

    // Round-robin search. Candidates are visited farthest-first so that the
    // last hit, which is the one kept, is the requester nearest to rr+1.
    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = REQS; k >= 1; k--) begin
            cand = IDW'((int'(rr) + k) % REQS);
            if (bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gating with reset keeps req_ready low while the block is held in reset.
    assign accept = (state == IDLE) && grant_vld && reset;

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every register samples pre-edge values; blocking (=) is for always_comb.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        req_ready_c = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready_c[grant_idx] = 1'b1;
                    state_nx               = ISSUE;
                end
            end
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the hold registers are reset along with the control state so the
    // cell never sees X inputs; a reset mid-transaction discards the operands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr          <= IDW'(REQS - 1);
            hold_sel    <= '0;
            hold_d      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (accept) begin
                hold_sel <= sel_arr[grant_idx];
                hold_d   <= d_arr[grant_idx];
                rsp_id_q <= grant_idx;
                rr       <= grant_idx;
            end
            // The cell registered its result at the end of ISSUE.
            if (state == CAPTURE) begin
                rsp_data_q  <= cell_out;
                rsp_valid_q <= 1'b1;
            end
            if ((state == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    assign {cell_A1, cell_B1, cell_A0, cell_B0}     = hold_sel;
    assign {cell_D11, cell_D10, cell_D01, cell_D00} = hold_d;
    assign cell_reset = ~reset;
    assign busy       = (state != IDLE);

endmodule
